// File: rtl/masked_hpc3_rand_scheduler.sv
// Shares one PRNG stream among NUM_REQ HPC3 multipliers; each grant hands out a unique (r, p) chunk from a 2-slot FIFO.
// Latency: request to grant 1 cycle (registered grant/data); a completed chunk is grantable from the next cycle.
// Backpressure: out_rand_ready drops while both chunk slots are full; requests wait while no chunk is stored.
module masked_hpc3_rand_scheduler #(
    parameter  int NUM_SHARES    = 2,
    parameter  int BIT_WIDTH     = 8,
    parameter  int NUM_REQ       = 3,
    parameter  int RAND_IN_WIDTH = 8,
    localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                                      in_clock,
    input  logic                                      in_reset,
    input  logic [RAND_IN_WIDTH-1:0]                  in_rand,
    input  logic                                      in_rand_valid,
    output logic                                      out_rand_ready,
    input  logic [NUM_REQ-1:0]                        in_req,
    output logic [NUM_REQ-1:0]                        out_grant,
    output logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]   out_r,
    output logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]   out_p,
    output logic                                      out_valid
);
    localparam int HALF  = NUM_QUADRATIC * BIT_WIDTH;
    localparam int CHUNK = 2 * HALF;
    localparam int WORDS = CHUNK / RAND_IN_WIDTH;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (CHUNK % RAND_IN_WIDTH != 0) begin : g_bad_rand_width
            $error("RAND_IN_WIDTH must divide the chunk width");
        end
    endgenerate

    logic [CHUNK-1:0]     slots [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [WCW-1:0]       word_cnt;
    logic [PW-1:0]        rr_ptr;
    logic                 active;

    logic                 accept;
    logic                 fill_done;
    logic                 grant_go;
    logic                 found;
    logic [PW-1:0]        pick;
    logic [2*NUM_REQ-1:0] rotated;
    logic [CHUNK-1:0]     head;

    assign out_rand_ready = active & (count != 2'd2);
    assign accept         = in_rand_valid & out_rand_ready;
    assign fill_done      = accept & (word_cnt == WCW'(WORDS - 1));
    assign grant_go       = (count != 2'd0) & found;
    assign head           = slots[rd_ptr];

    // Rotate so that bit 0 is the requester at rr_ptr; the lowest set bit wins.
    always_comb begin
        rotated = {in_req, in_req} >> rr_ptr;
        found   = 1'b0;
        pick    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && rotated[j]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr) + j) % NUM_REQ);
            end
        end
    end

    // Words land directly in the write slot; a partial chunk is simply forgotten on reset.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            for (int s = 0; s < 2; s++) slots[s] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            word_cnt <= '0;
            rr_ptr   <= '0;
            active   <= 1'b0;
        end else begin
            active <= 1'b1;
            if (accept) begin
                slots[wr_ptr][word_cnt*RAND_IN_WIDTH +: RAND_IN_WIDTH] <= in_rand;
                word_cnt <= fill_done ? '0 : word_cnt + 1'b1;
            end
            if (fill_done) wr_ptr <= ~wr_ptr;
            if (grant_go) begin
                rd_ptr <= ~rd_ptr;
                rr_ptr <= (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            end
            count <= count + {1'b0, fill_done} - {1'b0, grant_go};
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            out_grant <= '0;
            out_r     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else if (grant_go) begin
            out_grant <= NUM_REQ'(1) << pick;
            out_r     <= head[HALF-1:0];
            out_p     <= head[CHUNK-1:HALF];
            out_valid <= 1'b1;
        end else begin
            out_grant <= '0;
            out_r     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_masked_hpc3_rand_scheduler.sv
// Bench for masked_hpc3_rand_scheduler (defaults: one quadratic term, 16-bit chunk, 2 words per chunk, 3 requesters).
module tb_masked_hpc3_rand_scheduler;
    logic       in_clock = 1'b0;
    logic       in_reset = 1'b1;
    logic [7:0] in_rand;
    logic       in_rand_valid;
    logic       out_rand_ready;
    logic [2:0] in_req;
    logic [2:0] out_grant;
    logic [0:0][7:0] out_r;
    logic [0:0][7:0] out_p;
    logic       out_valid;

    int passed = 0;
    int total  = 0;

    // Reference state: stored chunks in arrival order, the chunk being assembled, next priority.
    logic [15:0] mq[$];
    logic [15:0] part;
    int          pcnt;
    int          rr;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] rq;
        logic       rdy;
        logic [2:0] eg;
        logic [7:0] er;
        logic [7:0] ep;
    } vec_t;

    vec_t tbl[$];

    masked_hpc3_rand_scheduler dut (
        .in_clock       (in_clock),
        .in_reset       (in_reset),
        .in_rand        (in_rand),
        .in_rand_valid  (in_rand_valid),
        .out_rand_ready (out_rand_ready),
        .in_req         (in_req),
        .out_grant      (out_grant),
        .out_r          (out_r),
        .out_p          (out_p),
        .out_valid      (out_valid)
    );

    always #5 in_clock = ~in_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_grant"}, 32'(out_grant), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_r"},     32'(out_r),     32'd0);
        chk({tag, "_p"},     32'(out_p),     32'd0);
    endtask

    task automatic do_reset();
        in_reset      = 1'b0;
        in_rand_valid = 1'b0;
        in_rand       = 8'h00;
        in_req        = 3'b000;
        repeat (2) @(negedge in_clock);
        check_zero_outputs("rst");
        chk("rst_ready", 32'(out_rand_ready), 32'd0);
        in_reset = 1'b1;
        mq.delete();
        part = 16'h0;
        pcnt = 0;
        rr   = 0;
        @(posedge in_clock);
        #1;
        chk("rel_ready", 32'(out_rand_ready), 32'd1);
        chk("rel_valid", 32'(out_valid), 32'd0);
        @(negedge in_clock);
    endtask

    // One cycle: drive at the falling edge, predict from the pre-edge model state, compare after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] rq);
        bit          gv;
        bit          acc;
        int          sel;
        int          k;
        logic [2:0]  eg;
        logic [15:0] ec;
        gv  = 0;
        sel = 0;
        eg  = 3'b000;
        ec  = 16'h0;
        in_rand_valid = v;
        in_rand       = d;
        in_req        = rq;
        #1;
        chk("ready", 32'(out_rand_ready), 32'(mq.size() < 2));
        acc = v && (mq.size() < 2);
        if (mq.size() > 0) begin
            for (int o = 0; o < 3; o++) begin
                k = (rr + o) % 3;
                if (!gv && rq[k]) begin
                    gv  = 1;
                    sel = k;
                end
            end
        end
        if (gv) begin
            eg = 3'(1 << sel);
            ec = mq.pop_front();
            rr = (sel + 1) % 3;
        end
        if (acc) begin
            part[pcnt*8 +: 8] = d;
            pcnt++;
            if (pcnt == 2) begin
                mq.push_back(part);
                pcnt = 0;
            end
        end
        @(posedge in_clock);
        #1;
        chk("grant", 32'(out_grant), 32'(eg));
        chk("valid", 32'(out_valid), 32'(gv));
        chk("r",     32'(out_r),     32'(ec[7:0]));
        chk("p",     32'(out_p),     32'(ec[15:8]));
        @(negedge in_clock);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("tbl%0d_ready", i), 32'(out_rand_ready), 32'(tbl[i].rdy));
            step(tbl[i].v, tbl[i].d, tbl[i].rq);
            chk($sformatf("tbl%0d_grant", i), 32'(out_grant), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_r", i),     32'(out_r),     32'(tbl[i].er));
            chk($sformatf("tbl%0d_p", i),     32'(out_p),     32'(tbl[i].ep));
        end
        tbl.delete();
    endtask

    initial begin
        in_reset      = 1'b0;
        in_rand_valid = 1'b0;
        in_rand       = 8'h00;
        in_req        = 3'b000;
        part = 16'h0;
        pcnt = 0;
        rr   = 0;
        do_reset();

        // Fill both slots, then drain them one grant at a time.
        tbl.push_back('{1'b1, 8'h11, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'h22, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'h33, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'h44, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 8'h00, 3'b001, 1'b0, 3'b001, 8'h11, 8'h22});
        tbl.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 8'h00, 3'b001, 1'b1, 3'b001, 8'h33, 8'h44});
        tbl.push_back('{1'b0, 8'h00, 3'b000, 1'b1, 3'b000, 8'h00, 8'h00});
        run_table();

        // Round robin with all three requesting and the PRNG always valid.
        do_reset();
        tbl.push_back('{1'b1, 8'hA1, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'hA2, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'hA3, 3'b111, 1'b1, 3'b001, 8'hA1, 8'hA2});
        tbl.push_back('{1'b1, 8'hA4, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'hA5, 3'b111, 1'b1, 3'b010, 8'hA3, 8'hA4});
        tbl.push_back('{1'b1, 8'hA6, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'hA7, 3'b111, 1'b1, 3'b100, 8'hA5, 8'hA6});
        tbl.push_back('{1'b1, 8'hA8, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'hA9, 3'b111, 1'b1, 3'b001, 8'hA7, 8'hA8});
        run_table();

        // No supply: requests must never produce a grant.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'hFF, 3'b111);
            check_zero_outputs("starve");
        end

        // Reset in the middle of a chunk discards the partial word.
        step(1'b1, 8'hAA, 3'b000);
        do_reset();
        step(1'b1, 8'h01, 3'b000);
        step(1'b1, 8'h02, 3'b000);
        step(1'b0, 8'h00, 3'b001);
        chk("midfill_r", 32'(out_r), 32'h01);
        chk("midfill_p", 32'(out_p), 32'h02);

        // Chunk completes in the same cycle a request rises: grant only at the following edge.
        do_reset();
        step(1'b1, 8'hB1, 3'b000);
        step(1'b1, 8'hB2, 3'b010);
        chk("nobypass_grant", 32'(out_grant), 32'd0);
        step(1'b0, 8'h00, 3'b010);
        chk("late_grant", 32'(out_grant), 32'b010);
        chk("late_r", 32'(out_r), 32'hB1);

        // Full FIFO plus a grant: one slot frees, the other chunk is still there.
        step(1'b1, 8'hC1, 3'b000);
        step(1'b1, 8'hC2, 3'b000);
        step(1'b1, 8'hC3, 3'b000);
        step(1'b1, 8'hC4, 3'b000);
        chk("full_ready", 32'(out_rand_ready), 32'd0);
        step(1'b1, 8'hC5, 3'b001);
        chk("fullgrant_r", 32'(out_r), 32'hC1);
        chk("after_full_ready", 32'(out_rand_ready), 32'd1);
        step(1'b0, 8'h00, 3'b100);
        chk("second_chunk_grant", 32'(out_grant), 32'b100);
        chk("second_chunk_p", 32'(out_p), 32'hC4);

        // Asynchronous reset while a grant is on the outputs.
        in_reset = 1'b0;
        #1;
        check_zero_outputs("async");
        do_reset();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
